icb_dma_master: RTL and testbench

ICB_DMA_MASTER -- requirements
Module: icb_dma_master

---
 rtl/icb_dma_master_if.sv | 43 ++++
 rtl/icb_dma_master.sv | 100 ++++++++++
 tb/tb_icb_dma_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_dma_master_if.sv
// Bundle of request, data-stream and ICB bus signals for icb_dma_master.
// The master modport is the DMA block's view; slave is the environment's view.
`timescale 1ns/1ps
interface icb_dma_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, icb_cmd_valid, icb_cmd_read,
           icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready, busy, done, err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, icb_cmd_valid, icb_cmd_read,
           icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready, busy, done, err
  );
endinterface

// File: rtl/icb_dma_master.sv
// Single-outstanding ICB DMA master: moves req_len words between the ICB bus
// and the rd/wr streams, with write data and read data passed straight through.
`timescale 1ns/1ps
module icb_dma_master (
  input logic               clk,
  input logic               rst_n,
  icb_dma_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        write_q;
  logic        err_q;
  logic        rsp_hs;
  logic        last_word;

  // cnt_q never exceeds len_q-1, so the increment cannot wrap.
  assign last_word = (cnt_q + 16'd1) == len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr & 32'hFFFF_FFFC;
        len_q   <= bus.req_len;
        write_q <= bus.req_write;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (rsp_hs) begin
        cnt_q  <= cnt_q + 16'd1;
        addr_q <= addr_q + 32'd4;
        err_q  <= err_q | bus.icb_rsp_err;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    rsp_hs            = 1'b0;
    bus.req_ready     = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.rd_valid      = 1'b0;
    bus.rd_data       = '0;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_rsp_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = rst_n;
        if (bus.req_valid) state_nxt = (bus.req_len != 16'd0) ? CMD : FIN;
      end
      CMD: begin
        if (write_q) begin
          bus.icb_cmd_valid = bus.wr_valid;
          bus.wr_ready      = bus.icb_cmd_ready;
          bus.icb_cmd_wdata = bus.wr_data;
          if (bus.wr_valid && bus.icb_cmd_ready) state_nxt = RSP;
        end else begin
          bus.icb_cmd_valid = 1'b1;
          bus.icb_cmd_read  = 1'b1;
          if (bus.icb_cmd_ready) state_nxt = RSP;
        end
      end
      RSP: begin
        if (write_q) begin
          bus.icb_rsp_ready = 1'b1;
          rsp_hs            = bus.icb_rsp_valid;
        end else begin
          bus.rd_valid      = bus.icb_rsp_valid;
          bus.rd_data       = bus.icb_rsp_rdata;
          bus.icb_rsp_ready = bus.rd_ready;
          rsp_hs            = bus.icb_rsp_valid & bus.rd_ready;
        end
        if (rsp_hs) state_nxt = last_word ? FIN : CMD;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.icb_cmd_addr  = addr_q;
  assign bus.icb_cmd_wmask = 4'hF;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == FIN);
  assign bus.err           = err_q;

endmodule

// File: tb/tb_icb_dma_master.sv
// Directed bench for icb_dma_master with a zero-wait ICB slave model.
`timescale 1ns/1ps
module tb_icb_dma_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icb_dma_master_if bus();

  icb_dma_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int d0;

  // Slave model: accepts commands, answers one cycle later; data = addr ^ 5A5A_0000.
  logic        pend  = 1'b0;
  logic [31:0] rdata = '0;
  logic        rerr  = 1'b0;
  logic        flush = 1'b0;
  int          err_idx = -1;
  int          done_cnt = 0;
  logic [31:0] cmd_addr_q[$];
  logic [31:0] cmd_wdata_q[$];
  logic        cmd_read_q[$];
  logic [3:0]  cmd_wmask_q[$];
  logic [31:0] rd_q[$];

  assign bus.icb_rsp_valid = pend;
  assign bus.icb_rsp_rdata = rdata;
  assign bus.icb_rsp_err   = rerr;

  always @(posedge clk) begin
    if (flush) pend <= 1'b0;
    else if (bus.icb_rsp_valid && bus.icb_rsp_ready) pend <= 1'b0;
    if (bus.icb_cmd_valid && bus.icb_cmd_ready) begin
      pend  <= 1'b1;
      rdata <= bus.icb_cmd_addr ^ 32'h5A5A_0000;
      rerr  <= (cmd_addr_q.size() == err_idx);
      cmd_addr_q.push_back(bus.icb_cmd_addr);
      cmd_wdata_q.push_back(bus.icb_cmd_wdata);
      cmd_read_q.push_back(bus.icb_cmd_read);
      cmd_wmask_q.push_back(bus.icb_cmd_wmask);
    end
    if (bus.rd_valid && bus.rd_ready) rd_q.push_back(bus.rd_data);
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_addr_q.delete();
    cmd_wdata_q.delete();
    cmd_read_q.delete();
    cmd_wmask_q.delete();
    rd_q.delete();
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [15:0] l);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // lat = number of cycles after the accept edge until done is seen.
  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.done) begin
        l = k;
        break;
      end
    end
    if (l < 0) check("done_timeout", 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic push_wr(input logic [31:0] d, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    for (int k = 0; k < 50; k++) begin
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wr_handshake", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b1; bus.icb_cmd_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_cmd_valid", 32'(bus.icb_cmd_valid), 0);
    check("rst_rsp_ready", 32'(bus.icb_rsp_ready), 0);
    check("rst_wr_ready", 32'(bus.wr_ready), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    #1 check("idle_req_ready", 32'(bus.req_ready), 1);

    // Read len=3 @0x1000
    clear_logs();
    d0 = done_cnt;
    start_req(1'b0, 32'h1000, 16'd3);
    wait_done(lat);
    check("rd3_lat", lat, 7);
    check("rd3_err", 32'(bus.err), 0);
    @(negedge clk);
    check("rd3_done_pulse", 32'(bus.done), 0);
    check("rd3_busy_after", 32'(bus.busy), 0);
    check("rd3_done_cnt", done_cnt - d0, 1);
    check("rd3_ncmd", cmd_addr_q.size(), 3);
    for (int i = 0; i < cmd_addr_q.size(); i++) begin
      check($sformatf("rd3_addr%0d", i), cmd_addr_q[i], 32'h1000 + 32'(4 * i));
      check($sformatf("rd3_read%0d", i), 32'(cmd_read_q[i]), 1);
    end
    check("rd3_nbeat", rd_q.size(), 3);
    for (int i = 0; i < rd_q.size(); i++)
      check($sformatf("rd3_data%0d", i), rd_q[i], (32'h1000 + 32'(4 * i)) ^ 32'h5A5A_0000);

    // Write len=2 @0x2003 with wr_valid gaps
    clear_logs();
    d0 = done_cnt;
    start_req(1'b1, 32'h2003, 16'd2);
    @(negedge clk);
    check("wr_gap_cmd_valid", 32'(bus.icb_cmd_valid), 0);
    check("wr_gap_wr_ready", 32'(bus.wr_ready), 1);
    fork
      begin
        push_wr(32'hA5A5_0001, 1);
        push_wr(32'hA5A5_0002, 2);
      end
      wait_done(lat);
    join
    @(negedge clk);
    check("wr_done_cnt", done_cnt - d0, 1);
    check("wr_ncmd", cmd_addr_q.size(), 2);
    for (int i = 0; i < cmd_addr_q.size(); i++) begin
      check($sformatf("wr_addr%0d", i), cmd_addr_q[i], 32'h2000 + 32'(4 * i));
      check($sformatf("wr_data%0d", i), cmd_wdata_q[i], 32'hA5A5_0001 + 32'(i));
      check($sformatf("wr_read%0d", i), 32'(cmd_read_q[i]), 0);
      check($sformatf("wr_mask%0d", i), 32'(cmd_wmask_q[i]), 32'hF);
    end
    check("wr_no_rd_beats", rd_q.size(), 0);

    // Read len=2 with rd_ready stalled; request during busy ignored
    clear_logs();
    bus.rd_ready = 1'b0;
    start_req(1'b0, 32'h3000, 16'd2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_ready", 32'(bus.icb_rsp_ready), 0);
      check("stall_rd_valid", 32'(bus.rd_valid), 1);
      if (i == 2) begin
        bus.req_valid = 1'b1;
        bus.req_len   = 16'd5;
        bus.req_addr  = 32'h7000;
        check("busy_req_ready", 32'(bus.req_ready), 0);
      end
      if (i == 3) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check("stall_ncmd", cmd_addr_q.size(), 1);
    bus.rd_ready = 1'b1;
    wait_done(lat);
    check("stall_ncmd_end", cmd_addr_q.size(), 2);
    check("stall_nbeat", rd_q.size(), 2);
    for (int i = 0; i < rd_q.size(); i++)
      check($sformatf("stall_data%0d", i), rd_q[i], (32'h3000 + 32'(4 * i)) ^ 32'h5A5A_0000);
    repeat (3) @(negedge clk);
    check("busy_req_dropped", 32'(bus.busy), 0);
    check("busy_req_nocmd", cmd_addr_q.size(), 2);

    // Response error on word 1: transfer completes, err sticky
    clear_logs();
    err_idx = 0;
    start_req(1'b0, 32'h5000, 16'd2);
    wait_done(lat);
    err_idx = -1;
    check("rsperr_lat", lat, 5);
    check("rsperr_ncmd", cmd_addr_q.size(), 2);
    check("rsperr_err", 32'(bus.err), 1);
    @(negedge clk);
    check("rsperr_err_held", 32'(bus.err), 1);

    // len=0: no ICB traffic, done one cycle after accept, err cleared on accept
    clear_logs();
    start_req(1'b0, 32'h6000, 16'd0);
    wait_done(lat);
    check("len0_lat", lat, 1);
    check("len0_err_clr", 32'(bus.err), 0);
    @(negedge clk);
    check("len0_ncmd", cmd_addr_q.size(), 0);
    check("len0_done_pulse", 32'(bus.done), 0);

    // Address wrap
    clear_logs();
    start_req(1'b0, 32'hFFFF_FFFC, 16'd2);
    wait_done(lat);
    check("wrap_ncmd", cmd_addr_q.size(), 2);
    if (cmd_addr_q.size() == 2) begin
      check("wrap_addr0", cmd_addr_q[0], 32'hFFFF_FFFC);
      check("wrap_addr1", cmd_addr_q[1], 32'h0000_0000);
    end

    // Reset while in RSP
    clear_logs();
    @(negedge clk);
    d0 = done_cnt;
    bus.rd_ready = 1'b0;
    start_req(1'b0, 32'h4000, 16'd2);
    repeat (2) @(negedge clk);
    check("rstrsp_busy_pre", 32'(bus.busy), 1);
    check("rstrsp_rd_valid_pre", 32'(bus.rd_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 bus.rd_ready = 1'b1;
    @(negedge clk);
    check("rstrsp_busy", 32'(bus.busy), 0);
    check("rstrsp_rsp_ready", 32'(bus.icb_rsp_ready), 0);
    check("rstrsp_rd_valid", 32'(bus.rd_valid), 0);
    check("rstrsp_cmd_valid", 32'(bus.icb_cmd_valid), 0);
    check("rstrsp_done", 32'(bus.done), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstrsp_no_done", done_cnt - d0, 0);
    check("rstrsp_ncmd", cmd_addr_q.size(), 1);
    check("rstrsp_req_ready", 32'(bus.req_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
